// File: rtl/if_stage.sv
// ============================================================================
// Module  : if_stage
// Brief   : MIPS32 instruction-fetch stage: PC, IF/ID register, stall,
//           redirect/flush, sticky halt and a retired-fetch counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             halt,
  output logic             if_id_valid,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc4,
  output logic [CNT_W-1:0] fetch_count,
  output logic             halted
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_plus4;
  logic             r_if_id_valid;
  logic [31:0]      r_if_id_instr;
  logic [31:0]      r_if_id_pc;
  logic [31:0]      r_if_id_pc4;
  logic [CNT_W-1:0] r_fetch_count;
  logic             r_halted;

  // Fetch address comes only from the PC register, never from control inputs.
  assign imem_addr   = r_pc;
  assign w_pc_plus4  = r_pc + 32'd4;

  assign if_id_valid = r_if_id_valid;
  assign if_id_instr = r_if_id_instr;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_pc4   = r_if_id_pc4;
  assign fetch_count = r_fetch_count;
  assign halted      = r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC & c_align_mask;
      r_if_id_valid <= 1'b0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc    <= 32'd0;
      r_if_id_pc4   <= 32'd0;
      r_fetch_count <= '0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (halt) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_state  <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (halt) begin
            r_state       <= ST_HALTED;
            r_halted      <= 1'b1;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
          end else if (redirect_valid) begin
            // Redirect wins over stall: the wrong-path slot is flushed.
            r_pc          <= redirect_target & c_align_mask;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
          end else if (!stall) begin
            r_if_id_valid <= 1'b1;
            r_if_id_instr <= imem_instr;
            r_if_id_pc    <= r_pc;
            r_if_id_pc4   <= w_pc_plus4;
            r_pc          <= w_pc_plus4;
            r_fetch_count <= r_fetch_count + CNT_W'(1);
          end
        end

        ST_HALTED: begin
          r_halted <= 1'b1;
        end

        default: begin
          r_state       <= ST_HALTED;
          r_halted      <= 1'b1;
          r_if_id_valid <= 1'b0;
          r_if_id_instr <= NOP_INSTR;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module  : tb_if_stage
// Brief   : Directed scoreboard bench for if_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] fetch_count;
  logic        halted;

  logic [31:0] mem [64];

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        hlt;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   fails;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP),
    .CNT_W    (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt           (halt),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .fetch_count    (fetch_count),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small instruction memory; higher addresses alias onto its 64 words.
  assign imem_instr = mem[imem_addr[7:2]];

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic v, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] pc4,
                      input logic [31:0] cnt, input logic h,
                      input logic [31:0] addr);
    exp_t e;
    e.tag = tag; e.valid = v; e.instr = instr; e.pc = pc; e.pc4 = pc4;
    e.cnt = cnt; e.hlt = h; e.addr = addr;
    q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the current outputs.
  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      cmp(e.tag, "valid",  {31'd0, if_id_valid}, {31'd0, e.valid});
      cmp(e.tag, "instr",  if_id_instr, e.instr);
      cmp(e.tag, "pc",     if_id_pc,    e.pc);
      cmp(e.tag, "pc4",    if_id_pc4,   e.pc4);
      cmp(e.tag, "count",  fetch_count, e.cnt);
      cmp(e.tag, "halted", {31'd0, halted}, {31'd0, e.hlt});
      cmp(e.tag, "addr",   imem_addr,   e.addr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] t,
                       input logic h);
    stall = s; redirect_valid = r; redirect_target = t; halt = h;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h2001_000A;
    mem[1] = 32'h2002_0014;
    mem[2] = 32'h0022_1820;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    push("reset", 1'b0, NOP, 32'h0, 32'h0, 32'd0, 1'b0, 32'h0);
    check_out();
    rst_n = 1'b1;

    // Boot cycle, then three fetches
    push("boot",  1'b0, NOP,           32'h0, 32'h0, 32'd0, 1'b0, 32'h0); tick();
    push("run0",  1'b1, 32'h2001_000A, 32'h0, 32'h4, 32'd1, 1'b0, 32'h4); tick();
    push("run1",  1'b1, 32'h2002_0014, 32'h4, 32'h8, 32'd2, 1'b0, 32'h8); tick();

    // Stall for two cycles at pc=8
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    push("stall0", 1'b1, 32'h2002_0014, 32'h4, 32'h8, 32'd2, 1'b0, 32'h8); tick();
    push("stall1", 1'b1, 32'h2002_0014, 32'h4, 32'h8, 32'd2, 1'b0, 32'h8); tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    push("unstall", 1'b1, 32'h0022_1820, 32'h8, 32'hC, 32'd3, 1'b0, 32'hC); tick();

    // Redirect overrides a simultaneous stall; target is word-aligned
    drive(1'b1, 1'b1, 32'h0000_0023, 1'b0);
    push("redir",  1'b0, NOP,     32'h8,  32'hC,  32'd3, 1'b0, 32'h20); tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    push("target", 1'b1, mem[8],  32'h20, 32'h24, 32'd4, 1'b0, 32'h24); tick();

    // PC wrap at the top of the address space
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    push("wrap_redir", 1'b0, NOP, 32'h20, 32'h24, 32'd4, 1'b0, 32'hFFFF_FFFC); tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    push("wrap_top", 1'b1, mem[63], 32'hFFFF_FFFC, 32'h0, 32'd5, 1'b0, 32'h0); tick();
    push("wrap_low", 1'b1, mem[0],  32'h0,         32'h4, 32'd6, 1'b0, 32'h4); tick();
    push("run_a", 1'b1, mem[1], 32'h4, 32'h8,  32'd7, 1'b0, 32'h8);  tick();
    push("run_b", 1'b1, mem[2], 32'h8, 32'hC,  32'd8, 1'b0, 32'hC);  tick();
    push("run_c", 1'b1, mem[3], 32'hC, 32'h10, 32'd9, 1'b0, 32'h10); tick();

    // Halt beats a simultaneous redirect and is sticky
    drive(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    push("halt", 1'b0, NOP, 32'hC, 32'h10, 32'd9, 1'b1, 32'h10); tick();
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    push("halt_stall", 1'b0, NOP, 32'hC, 32'h10, 32'd9, 1'b1, 32'h10); tick();
    drive(1'b0, 1'b1, 32'h0000_0080, 1'b0);
    push("halt_redir", 1'b0, NOP, 32'hC, 32'h10, 32'd9, 1'b1, 32'h10); tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    push("halt_idle", 1'b0, NOP, 32'hC, 32'h10, 32'd9, 1'b1, 32'h10); tick();

    // Reset out of HALTED, boot, then five fetches
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    push("reboot", 1'b0, NOP, 32'h0, 32'h0, 32'd0, 1'b0, 32'h0); tick();
    for (int i = 0; i < 5; i++) begin
      push($sformatf("refetch%0d", i), 1'b1, mem[i], 32'(i * 4), 32'(i * 4 + 4),
           32'(i + 1), 1'b0, 32'(i * 4 + 4));
      tick();
    end

    // Asynchronous reset between edges takes effect at once
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", 1'b0, NOP, 32'h0, 32'h0, 32'd0, 1'b0, 32'h0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    push("boot2", 1'b0, NOP,    32'h0, 32'h0, 32'd0, 1'b0, 32'h0); tick();
    push("run2",  1'b1, mem[0], 32'h0, 32'h4, 32'd1, 1'b0, 32'h4); tick();

    tests++;
    assert (q.size() == 0)
    else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
